// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcode/funct constants, the legal opcode
// list, PC mux select encodings, exception cause codes and the PC sequencer
// state/decode-class types.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_RTE   = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  localparam int unsigned NUM_VALID_OPCODES = 13;
  localparam logic [5:0] VALID_OPCODES [NUM_VALID_OPCODES] = '{
    OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
    OP_ANDI, OP_ORI, OP_LUI, OP_RTE, OP_LW, OP_SW
  };

  localparam logic [2:0] PC_SRC_ALU    = 3'd0;
  localparam logic [2:0] PC_SRC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_EXCVEC = 3'd3;
  localparam logic [2:0] PC_SRC_MDR    = 3'd4;
  localparam logic [2:0] PC_SRC_EPC    = 3'd5;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE, ST_INC, ST_BR, ST_JMP, ST_RTE, ST_ARITH, ST_FIN,
    ST_EXC_SAVE, ST_EXC_VEC, ST_EXC_RD, ST_EXC_LD
  } pc_seq_state_t;

  typedef enum logic [2:0] {
    CLS_FIN, CLS_BR, CLS_JMP, CLS_RTE, CLS_EXC, CLS_ARITH
  } pc_seq_class_t;

  // True when op appears in the legal opcode list.
  function automatic logic is_valid_opcode(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_VALID_OPCODES; i++)
      if (VALID_OPCODES[i] == op) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/pc_sequencer_decode.sv
// Combinational opcode/funct classifier for the PC sequencer.
// Macro PC_SEQ_OVF_TRAP_EN: add/sub/addi classify as ARITH (overflow-checked);
// otherwise they complete like any other non-control-flow instruction.
module pc_seq_decode
  import cpu_pkg::*;
(
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  output pc_seq_class_t cls
);

`ifdef PC_SEQ_OVF_TRAP_EN
  localparam pc_seq_class_t ARITH_CLS = CLS_ARITH;
`else
  localparam pc_seq_class_t ARITH_CLS = CLS_FIN;
`endif

  // Map the sampled instruction to the sequence it needs.
  always_comb begin
    cls = CLS_FIN;
    if (!is_valid_opcode(opcode)) begin
      cls = CLS_EXC;
    end else begin
      unique case (opcode)
        OP_BEQ, OP_BNE: cls = CLS_BR;
        OP_J, OP_JAL:   cls = CLS_JMP;
        OP_RTE:         cls = CLS_RTE;
        OP_ADDI:        cls = ARITH_CLS;
        OP_RTYPE:       if (funct == FN_ADD || funct == FN_SUB) cls = ARITH_CLS;
        default:        cls = CLS_FIN;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC-source / PC-write / EPC-write sequencer for the multicycle CPU.
// Optional overflow trapping is enabled with macro PC_SEQ_OVF_TRAP_EN
// (handled inside pc_seq_decode).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic [2:0] pc_src,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_rd,
  output logic [1:0] exc_cause,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  pc_seq_state_t state, state_d;
  pc_seq_class_t cls;
  logic [CW-1:0] cnt;
  logic [2:0]    pc_src_q;
  logic [1:0]    exc_cause_d;
  logic          is_bne, is_bne_d;

  pc_seq_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // State, table-read latency counter, branch sense, cause and held mux select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_bne    <= 1'b0;
      exc_cause <= EXC_NONE;
      pc_src_q  <= PC_SRC_ALU;
    end else begin
      state     <= state_d;
      is_bne    <= is_bne_d;
      exc_cause <= exc_cause_d;
      pc_src_q  <= pc_src;
      if (state == ST_EXC_RD && cnt != CNT_LAST) cnt <= cnt + 1'b1;
      else                                      cnt <= '0;
    end
  end

  // Next state and Moore outputs; pc_src re-presents the last select in
  // states that do not drive the mux so the PC input never glitches.
  always_comb begin
    state_d     = state;
    pc_src      = pc_src_q;
    pc_write    = 1'b0;
    epc_write   = 1'b0;
    mem_rd      = 1'b0;
    done        = 1'b0;
    exc_cause_d = exc_cause;
    is_bne_d    = is_bne;
    unique case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          exc_cause_d = EXC_NONE;
          is_bne_d    = (opcode == OP_BNE);
          unique case (cls)
            CLS_BR:    state_d = ST_BR;
            CLS_JMP:   state_d = ST_JMP;
            CLS_RTE:   state_d = ST_RTE;
            CLS_ARITH: state_d = ST_ARITH;
            CLS_EXC: begin
              state_d     = ST_EXC_SAVE;
              exc_cause_d = EXC_INVALID;
            end
            default:   state_d = ST_FIN;
          endcase
        end else if (fetch_req) begin
          exc_cause_d = EXC_NONE;
          state_d     = ST_INC;
        end
      end
      ST_INC: begin
        pc_src   = PC_SRC_ALU;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_BR: begin
        pc_src   = PC_SRC_ALUOUT;
        pc_write = is_bne ? ~alu_zero : alu_zero;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_JMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_RTE: begin
        pc_src   = PC_SRC_EPC;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ARITH: begin
        if (alu_overflow) begin
          state_d     = ST_EXC_SAVE;
          exc_cause_d = EXC_OVF;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_EXC_SAVE: begin
        epc_write = 1'b1;
        state_d   = ST_EXC_VEC;
      end
      ST_EXC_VEC: begin
        pc_src   = PC_SRC_EXCVEC;
        pc_write = 1'b1;
        state_d  = ST_EXC_RD;
      end
      ST_EXC_RD: begin
        mem_rd = 1'b1;
        if (cnt == CNT_LAST) state_d = ST_EXC_LD;
      end
      ST_EXC_LD: begin
        pc_src   = PC_SRC_MDR;
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
